// File: rtl/bgw_renderer.sv
// rtl/bgw_renderer.sv - background/window tile renderer with per-slot VRAM prefetch
module bgw_renderer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int H_FP   = 23,
  parameter int H_SYNC = 28,
  parameter int H_BP   = 45,
  parameter int V_FP   = 6,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 20,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  h_count,
  input  logic [8:0]  v_count,
  input  logic        o_de,
  input  logic [8:0]  o_h,
  input  logic [7:0]  o_v,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic [13:0] vram32_addr,
  input  logic [31:0] vram32_q,
  output logic [13:0] vram8_addr,
  input  logic [7:0]  vram8_q
);

  localparam int HA_STA = H_FP - 1 + H_SYNC + H_BP;
  localparam int VA_STA = V_FP - 1 + V_SYNC + V_BP;

  // Horizontal landmarks: scroll parameter reads, fetch slot window, active pixel computation.
  localparam logic [9:0] H_PRM0  = 10'(HA_STA - 19);
  localparam logic [9:0] H_PRM1  = 10'(HA_STA - 18);
  localparam logic [9:0] H_PRM2  = 10'(HA_STA - 17);
  localparam logic [9:0] H_SLOT0 = 10'(HA_STA - 15);
  localparam logic [9:0] H_SLOTN = 10'(HA_STA - 15 + 8 * 41);
  localparam logic [9:0] H_ACT0  = 10'(HA_STA);
  localparam logic [9:0] H_ACT1  = 10'(HA_STA + H_RES - 1);
  localparam logic [8:0] V_ACT0  = 9'(VA_STA + 1);
  localparam logic [8:0] V_ACT1  = 9'(VA_STA + V_RES);
  localparam logic [5:0] LAST_SLOT = 6'd40;

  // Line-wide scroll state; line_ok_q stays low until a full line's parameters have been read.
  logic [5:0]  tile_off_q;
  logic [2:0]  fine_q;
  logic        line_ok_q;

  // Per-slot capture registers (tile/colour bytes, then pattern half-word and palette word).
  logic [7:0]  bg_tile_q, win_tile_q;
  logic [4:0]  bg_pal_q, win_pal_q;
  logic [15:0] bg_pat_s_q, win_pat_s_q;
  logic [31:0] bg_col_s_q, win_col_s_q;

  // Two-entry tile buffers indexed by tile parity, so a tile can be drawn while the next lands.
  logic [15:0] bg_pat_q  [2];
  logic [31:0] bg_col_q  [2];
  logic [15:0] win_pat_q [2];
  logic [31:0] win_col_q [2];

  logic [7:0]  pix_d, pix_q;

  logic        line_act, in_slot, win_en, pix_act, out_en;
  logic [7:0]  y;
  logic [4:0]  ty;
  logic [9:0]  rel;
  logic [5:0]  slot_k, bg_tx;
  logic [2:0]  phase;
  logic [3:0]  px_lo, s_lo;
  logic [1:0]  bg_idx, win_idx;

  function automatic logic [1:0] pat_idx(input logic [15:0] pat, input logic [2:0] col);
    logic [15:0] sh;
    sh = pat << {col, 1'b0};
    return sh[15:14];
  endfunction

  function automatic logic [7:0] pal_byte(input logic [31:0] w, input logic [1:0] i);
    logic [31:0] sh;
    sh = w << {i, 3'b000};
    return sh[31:24];
  endfunction

  assign line_act = (v_count >= V_ACT0) && (v_count <= V_ACT1);
  assign y        = 8'(v_count - V_ACT0);
  assign ty       = y[7:3];
  assign in_slot  = line_act && (h_count >= H_SLOT0) && (h_count < H_SLOTN);
  assign rel      = h_count - H_SLOT0;
  assign slot_k   = rel[8:3];
  assign phase    = rel[2:0];
  assign bg_tx    = slot_k + tile_off_q;
  assign win_en   = (slot_k != LAST_SLOT);

  // VRAM address sequencing: parameter reads, then the per-slot tile/colour/pattern/palette fetches.
  always_comb begin
    vram8_addr  = '0;
    vram32_addr = '0;
    if (!reset && line_act) begin
      if (h_count == H_PRM0) vram8_addr = 14'h2000;
      if (h_count == H_PRM1) vram8_addr = 14'h2001;
      if (in_slot) begin
        case (phase)
          3'd0: vram8_addr = {3'b000, ty, bg_tx};
          3'd1: vram8_addr = {3'b001, ty, bg_tx};
          3'd2: begin
            if (win_en) vram8_addr = {3'b010, ty, slot_k};
            vram32_addr = {4'b0000, bg_tile_q, y[2:1]};
          end
          3'd3: begin
            if (win_en) vram8_addr = {3'b011, ty, slot_k};
            vram32_addr = {4'b0001, 5'b00000, bg_pal_q};
          end
          3'd4: if (win_en) vram32_addr = {4'b0000, win_tile_q, y[2:1]};
          3'd5: if (win_en) vram32_addr = {4'b0001, 5'b00000, win_pal_q};
          default: ;
        endcase
      end
    end
  end

  // Capture each read one cycle after its address, then commit the slot into its parity buffer.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      tile_off_q  <= '0;
      fine_q      <= '0;
      line_ok_q   <= 1'b0;
      bg_tile_q   <= '0;
      win_tile_q  <= '0;
      bg_pal_q    <= '0;
      win_pal_q   <= '0;
      bg_pat_s_q  <= '0;
      win_pat_s_q <= '0;
      bg_col_s_q  <= '0;
      win_col_s_q <= '0;
      for (int i = 0; i < 2; i++) begin
        bg_pat_q[i]  <= '0;
        bg_col_q[i]  <= '0;
        win_pat_q[i] <= '0;
        win_col_q[i] <= '0;
      end
    end else begin
      if (line_act && h_count == H_PRM1) begin
        tile_off_q <= vram8_q[5:0];
        line_ok_q  <= 1'b1;
      end
      if (line_act && h_count == H_PRM2) fine_q <= vram8_q[2:0];
      if (in_slot) begin
        case (phase)
          3'd1: bg_tile_q  <= vram8_q;
          3'd2: bg_pal_q   <= vram8_q[4:0];
          3'd3: begin
            win_tile_q <= vram8_q;
            bg_pat_s_q <= y[0] ? vram32_q[15:0] : vram32_q[31:16];
          end
          3'd4: begin
            win_pal_q  <= vram8_q[4:0];
            bg_col_s_q <= vram32_q;
          end
          3'd5: win_pat_s_q <= y[0] ? vram32_q[15:0] : vram32_q[31:16];
          3'd6: win_col_s_q <= vram32_q;
          3'd7: begin
            bg_pat_q[slot_k[0]] <= bg_pat_s_q;
            bg_col_q[slot_k[0]] <= bg_col_s_q;
            if (win_en) begin
              win_pat_q[slot_k[0]] <= win_pat_s_q;
              win_col_q[slot_k[0]] <= win_col_s_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Pixel for the next output cycle: BG at scrolled stream position, window on top when opaque.
  always_comb begin
    pix_d   = '0;
    pix_act = line_act && line_ok_q && (h_count >= H_ACT0) && (h_count <= H_ACT1);
    px_lo   = 4'(h_count - H_ACT0);
    s_lo    = px_lo + {1'b0, fine_q};
    bg_idx  = pat_idx(bg_pat_q[s_lo[3]], s_lo[2:0]);
    win_idx = pat_idx(win_pat_q[px_lo[3]], px_lo[2:0]);
    if (pix_act) begin
      if (win_idx != 2'd0) pix_d = pal_byte(win_col_q[px_lo[3]], win_idx);
      else                 pix_d = pal_byte(bg_col_q[s_lo[3]], bg_idx);
    end
  end

  // Output pixel register.
  always_ff @(posedge vga_clk) begin
    if (reset) pix_q <= '0;
    else       pix_q <= pix_d;
  end

  assign out_en = o_de && !reset;
  assign vga_r  = out_en ? pix_q[7:5] : 3'b000;
  assign vga_g  = out_en ? pix_q[4:2] : 3'b000;
  assign vga_b  = out_en ? pix_q[1:0] : 2'b00;

  logic unused_ok;
  assign unused_ok = ^{o_h, o_v, rel[9], H_POL, V_POL};

endmodule

// File: tb/tb_bgw_renderer.sv
// tb/tb_bgw_renderer.sv - table-driven self-checking bench for bgw_renderer
module tb_bgw_renderer;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  h_count;
  logic [8:0]  v_count;
  logic        o_de;
  logic [8:0]  o_h;
  logic [7:0]  o_v;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;
  logic [13:0] vram32_addr, vram8_addr;
  logic [31:0] vram32_q;
  logic [7:0]  vram8_q;

  always #5 vga_clk = ~vga_clk;

  bgw_renderer dut (
    .vga_clk(vga_clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .o_de(o_de), .o_h(o_h), .o_v(o_v),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vram32_addr(vram32_addr), .vram32_q(vram32_q),
    .vram8_addr(vram8_addr), .vram8_q(vram8_q)
  );

  logic [31:0] m32 [16384];
  logic [7:0]  m8  [16384];

  always @(posedge vga_clk) begin
    vram32_q <= m32[vram32_addr];
    vram8_q  <= m8[vram8_addr];
  end

  typedef struct {
    int         scen;
    int         y;
    int         x;
    logic [7:0] exp;
  } vec_t;

  vec_t        vq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  pix [320];
  logic [13:0] a8  [416];
  logic [13:0] a32 [416];
  int          blank_bad, rst_bad, addr_bad;
  int          g_fine, g_toff;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] grid_px(input int x, input int fine, input int toff);
    int s, t;
    s = x + fine;
    t = ((s / 8) + toff) % 64;
    return 8'(((t % 32) * 8) + (s % 4));
  endfunction

  task automatic setup_scene(input int s);
    for (int i = 0; i < 16384; i++) begin
      m32[i] = '0;
      m8[i]  = '0;
    end
    g_fine = 0;
    g_toff = 0;
    case (s)
      1: m32[1024] = 32'hE000_0000;
      2, 3: begin
        m8[0]     = 8'd1;
        m32[4]    = 32'h1B00_C000;
        m32[1024] = 32'h00E0_1C03;
        if (s == 3) begin
          m8[14'h1000] = 8'd2;
          m8[14'h1800] = 8'd5;
          m32[8]       = 32'h3000_0000;
          m32[1029]    = 32'h1122_3344;
        end
      end
      default: begin
        for (int c = 0; c < 64; c++) begin
          m8[c]              = 8'(c);
          m8[14'h0800 + c]   = 8'(c % 32);
          m8[14'h1000 + c]   = 8'd64;
          m32[4 * c]         = 32'h1B1B_0000;
        end
        for (int p = 0; p < 32; p++)
          m32[1024 + p] = {8'(p * 8), 8'(p * 8 + 1), 8'(p * 8 + 2), 8'(p * 8 + 3)};
        if (s == 4) g_fine = 3;
        if (s == 5) g_fine = 7;
        if (s == 6) g_toff = 63;
        m8[14'h2000] = 8'(8'hC0 | g_toff);
        m8[14'h2001] = 8'(8'hF8 | g_fine);
      end
    endcase
  endtask

  task automatic run_line(input int vline, input int rst_at);
    logic [7:0] o;
    blank_bad = 0;
    rst_bad   = 0;
    addr_bad  = 0;
    for (int h = 0; h < 416; h++) begin
      @(posedge vga_clk);
      #1;
      h_count = 10'(h);
      v_count = 9'(vline);
      o_de    = (vline >= 29 && vline <= 268 && h >= 96 && h <= 415);
      o_h     = o_de ? 9'(h - 96) : 9'd0;
      o_v     = o_de ? 8'(vline - 29) : 8'd0;
      reset   = (rst_at >= 0 && h >= rst_at && h < rst_at + 3);
      @(negedge vga_clk);
      o = {vga_r, vga_g, vga_b};
      a8[h]  = vram8_addr;
      a32[h] = vram32_addr;
      if (vram8_addr != 0 || vram32_addr != 0) addr_bad++;
      if (o_de) pix[h - 96] = o;
      else if (o != 0) blank_bad++;
      if (reset && (o != 0 || vram8_addr != 0 || vram32_addr != 0)) rst_bad++;
    end
    reset = 1'b0;
  endtask

  initial begin
    int cur_scen, cur_y, bad;
    reset = 1'b1; h_count = '0; v_count = '0; o_de = 1'b0; o_h = '0; o_v = '0;
    setup_scene(1);
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    check("reset_vga", int'({vga_r, vga_g, vga_b}), 0);
    check("reset_addr", int'(vram8_addr) + int'(vram32_addr), 0);
    reset = 1'b0;

    vq.push_back('{1, 0, 0, 8'hE0});   vq.push_back('{1, 0, 319, 8'hE0});
    vq.push_back('{1, 239, 160, 8'hE0});
    vq.push_back('{2, 0, 0, 8'h00});   vq.push_back('{2, 0, 1, 8'hE0});
    vq.push_back('{2, 0, 2, 8'h1C});   vq.push_back('{2, 0, 3, 8'h03});
    vq.push_back('{2, 0, 8, 8'h00});   vq.push_back('{2, 1, 0, 8'h03});
    vq.push_back('{2, 1, 1, 8'h00});
    vq.push_back('{3, 0, 0, 8'h00});   vq.push_back('{3, 0, 1, 8'h44});
    vq.push_back('{3, 0, 2, 8'h1C});   vq.push_back('{3, 0, 3, 8'h03});
    vq.push_back('{4, 0, 0, 8'h03});   vq.push_back('{4, 0, 5, 8'h08});
    vq.push_back('{4, 0, 316, 8'h3B}); vq.push_back('{4, 0, 317, 8'h40});
    vq.push_back('{4, 0, 319, 8'h42});
    vq.push_back('{5, 0, 0, 8'h03});   vq.push_back('{5, 0, 1, 8'h08});
    vq.push_back('{5, 0, 319, 8'h42});
    vq.push_back('{6, 0, 0, 8'hF8});   vq.push_back('{6, 0, 7, 8'hFB});
    vq.push_back('{6, 0, 8, 8'h00});   vq.push_back('{6, 0, 9, 8'h01});
    vq.push_back('{6, 0, 16, 8'h08});
    vq.push_back('{7, 0, 3, 8'h03});   vq.push_back('{7, 0, 317, 8'h39});
    vq.push_back('{7, 0, 319, 8'h3B});

    cur_scen = -1;
    cur_y    = -1;
    foreach (vq[i]) begin
      if (vq[i].scen != cur_scen || vq[i].y != cur_y) begin
        if (vq[i].scen != cur_scen) setup_scene(vq[i].scen);
        cur_scen = vq[i].scen;
        cur_y    = vq[i].y;
        run_line(29 + cur_y, -1);
        check($sformatf("blank_zero_s%0d_y%0d", cur_scen, cur_y), blank_bad, 0);
        bad = 0;
        for (int x = 0; x < 320; x++) begin
          if (cur_scen == 1 && pix[x] != 8'hE0) bad++;
          if (cur_scen >= 4 && pix[x] != grid_px(x, g_fine, g_toff)) bad++;
        end
        if (cur_scen == 1 || cur_scen >= 4)
          check($sformatf("line_model_s%0d_y%0d", cur_scen, cur_y), bad, 0);
      end
      check($sformatf("px_s%0d_y%0d_x%0d", vq[i].scen, vq[i].y, vq[i].x),
            int'(pix[vq[i].x]), int'(vq[i].exp));
    end

    // Address schedule of the last (unscrolled grid) line.
    check("addr_prm_tile", int'(a8[76]), 14'h2000);
    check("addr_prm_fine", int'(a8[77]), 14'h2001);
    check("addr_idle_79", int'(a8[79]) + int'(a32[79]), 0);
    check("addr_s1_bgtile", int'(a8[88]), 14'h0001);
    check("addr_s1_bgcol", int'(a8[89]), 14'h0801);
    check("addr_s1_wintile", int'(a8[90]), 14'h1001);
    check("addr_s1_wincol", int'(a8[91]), 14'h1801);
    check("addr_s1_pat", int'(a32[90]), 4);
    check("addr_s1_pal", int'(a32[91]), 1025);
    check("addr_s40_bgtile", int'(a8[400]), 40);
    check("addr_s40_nowin", int'(a8[402]), 0);
    check("addr_idle_408", int'(a8[408]) + int'(a32[408]), 0);

    // Blank line: no fetch activity and no colour.
    run_line(5, -1);
    check("blank_line_addr", addr_bad, 0);
    check("blank_line_vga", blank_bad, 0);

    // Reset held 3 cycles mid-line, then the rest of the line stays black.
    setup_scene(1);
    run_line(29 + 10, 200);
    check("rst_hold_zero", rst_bad, 0);
    check("pre_rst_px", int'(pix[50]), 8'hE0);
    bad = 0;
    for (int x = 104; x < 320; x++) if (pix[x] != 0) bad++;
    check("rst_stay_zero", bad, 0);
    run_line(29 + 11, -1);
    bad = 0;
    for (int x = 0; x < 320; x++) if (pix[x] != 8'hE0) bad++;
    check("post_rst_line", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bgw_renderer.md
# bgw_renderer

Background/window tile renderer for the 320x240 GPU. Driven by the display timing counters. Fetches tile, color, pattern and palette data from two VRAMs ahead of the beam. Outputs the composited 8-bit RGB colour of each active pixel, which the frame synthesizer merges with the sprite layer. The background scrolls horizontally; the window is fixed and overlays it.

## Interface
- H_RES, 320; V_RES, 240; H_FP, 23; H_SYNC, 28; H_BP, 45; V_FP, 6; V_SYNC, 3; V_BP, 20; H_POL, 0; V_POL, 0 — timing parameters, identical to the synthesizer.
- Derived: HA_STA = H_FP-1+H_SYNC+H_BP (95 with defaults); VA_STA = V_FP-1+V_SYNC+V_BP.
- One clock; reset is synchronous and active-high.
- vga_clk  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  synchronous active-high reset.
- h_count  in  10  line position, 0..HA_STA+H_RES.
- v_count  in  9  frame line, 0..VA_STA+V_RES.
- o_de  in  1  active-pixel flag.
- o_h  in  9  active x, 0..319.
- o_v  in  8  active y, 0..239.
- vga_r  out  3  pixel red.
- vga_g  out  3  pixel green.
- vga_b  out  2  pixel blue.
- vram32_addr  out  14  VRAM32 read address.
- vram32_q  in  32  VRAM32 data; valid the cycle after the address is presented.
- vram8_addr  out  14  VRAM8 read address.
- vram8_q  in  8  VRAM8 data; same 1-cycle latency.

## Operation
- VRAM32 map:
  - Pattern table at 0..1023, 4 words per pattern.
  - Word w of pattern p is at p*4+w and holds tile lines 2w (bits 31:16) and 2w+1 (bits 15:0).
  - Pixel column c of a line is bits [15-2c:14-2c] of that half-word, giving a 2-bit color index.
  - Palette table at 1024..1055, one word per palette. Color index i selects byte i (i=0 is bits 31:24).
  - A color byte maps to r=[7:5], g=[4:2], b=[1:0].
- VRAM8 map:
  - BG tile table at 0x0000, 64x32 tiles, row-major, index ty*64+tx.
  - BG color table at 0x0800, same layout.
  - Window tile table at 0x1000, 64-wide rows; only columns 0..39 are used.
  - Window color table at 0x1800.
  - Tile X offset at 0x2000; bits 5:0 are used.
  - Fine X offset at 0x2001; bits 2:0 are used.
  - Color-table byte bits 4:0 give the palette number.
- Per active line with y=o_v, the tile row is ty=y>>3 and the tile line is y[2:0].
- Scroll parameters are read once per line and held for the whole line.
- BG pixel x uses stream position s=x+fine:
  - tile column tx=((s>>3)+tile_offset) mod 64;
  - pixel column s&7.
- Window pixel x uses tile column x>>3 and pixel column x&7; it is unscrolled.
- Compositing:
  - If the window color index is nonzero, output the window palette color.
  - Otherwise output the BG palette color; index 0 is opaque on BG.
- Outside active pixels, vga_r/g/b = 0.
- Reset clears outputs, both addresses and all internal registers to 0.
- vram addresses are 0 when not fetching.

## Timing
- Pixel x appears on vga_* in the cycle where h_count = HA_STA+1+x, aligned with o_de. It is registered inside the block, so the synthesizer applies no further delay.
- Parameter reads: vram8_addr=0x2000 at h_count=HA_STA-19 and 0x2001 at HA_STA-18, for lines where v_count is in VA_STA+1..VA_STA+V_RES.
- Fetch slots k=0..40 start at h_count=HA_STA-15+8k; each lasts 8 cycles.
  - The slot fetches BG tile, BG color, window tile and window color (window only for k<40).
  - It then fetches the pattern word ((tile<<2)|y[2:1]) and palette (1024+pal) for each layer.
  - Every q is captured exactly one cycle after its address.
- Slot k data must be usable by the pixel at h_count=HA_STA-6+8k, which is the worst case with fine=7.
- A 41st BG slot covers fine scroll; it must not corrupt pixel 319.
- tx wraps 63→0 within a line.
- No fetches or address activity on blank lines.
- Reset asserted mid-line: outputs 0 immediately. Correct pixels resume from the next full line after reset is released.

## Test plan
- Reset held 3 cycles mid-frame -> vga_*=0 and both addrs=0 during reset. Output stays 0 until the next line start.
- All VRAM 0 except palette 0 (addr 1024) = 0xE0000000 -> every active pixel r=7,g=0,b=0; blanking 0.
- BG tile (0,0)=1, pattern 1 word0=0x1B000000, palette 0=0x00E01C03:
  - line 0 pixels 0..3 = colors byte0,1,2,3, i.e. (0,0,0),(7,0,0),(0,7,0),(0,0,3);
  - line 1 uses bits 15:0.
- Window tile (0,0)=2 with pattern 2 having index 0 at column 0 and index 3 at column 1, window color=palette 5 -> pixel 0 shows BG and pixel 1 shows palette 5 byte 3.
- Fine offset 3, tile offset 0 -> pixel 0 equals unscrolled pixel 3. Pixel 317 equals unscrolled tile 40 column 0.
- Tile offset 63, fine 0 -> pixels 0..7 come from BG column 63 and pixels 8..15 from column 0 (wrap).
